// File: rtl/xor_share_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : xor_share_arbiter_if
// Brief    : Request/operand/grant/result bundle for the shared-XOR arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface xor_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] a_in;
    logic [4*WIDTH-1:0] b_in;
    logic [3:0]         gnt;
    logic               busy;
    logic               done;
    logic [1:0]         done_id;
    logic [WIDTH-1:0]   result;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, done_id, result
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, done_id, result
    );
endinterface

`default_nettype wire

// File: rtl/xor_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : xor_share_arbiter
// Brief    : Round-robin 4-way arbiter feeding one bit-serial NAND-built XOR cell.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module xor_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  wire                 clk,
    input  wire                 rst_n,
    xor_share_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam int         CNT_W   = $clog2(WIDTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic [1:0]       last_q, last_d;
    logic [1:0]       done_id_q, done_id_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_any_req;
    logic             w_found;
    logic [1:0]       w_idx;
    logic [1:0]       w_winner;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_acc_next;

    // The single shared XOR cell: four 2-input NANDs on the operand LSBs.
    logic w_nand_ab, w_nand_a, w_nand_b, w_xor;
    assign w_nand_ab = ~(a_sh_q[0] & b_sh_q[0]);
    assign w_nand_a  = ~(a_sh_q[0] & w_nand_ab);
    assign w_nand_b  = ~(b_sh_q[0] & w_nand_ab);
    assign w_xor     = ~(w_nand_a & w_nand_b);

    assign w_acc_next = {w_xor, acc_q[WIDTH-1:1]};
    assign w_last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Search upward from the requester after the last one served, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_winner  = 2'd0;
        w_idx     = 2'd0;
        w_any_req = |bus.req;
        for (int k = 1; k <= 4; k++) begin
            w_idx = last_q + 2'(k);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_any_req) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (w_last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.gnt     = gnt_q;
        bus.done_id = done_id_q;
        bus.result  = result_q;
    end

    always_comb begin
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        done_id_d = done_id_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        acc_d     = acc_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    gnt_d    = 4'b0001 << w_winner;
                    gnt_id_d = w_winner;
                end else begin
                    gnt_d    = 4'b0000;
                end
            end
            S_LOAD: begin
                a_sh_d = bus.a_in[gnt_id_q*WIDTH +: WIDTH];
                b_sh_d = bus.b_in[gnt_id_q*WIDTH +: WIDTH];
                acc_d  = '0;
                cnt_d  = '0;
            end
            S_SHIFT: begin
                acc_d  = w_acc_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (w_last_bit) begin
                    result_d  = w_acc_next;
                    done_id_d = gnt_id_q;
                    last_d    = gnt_id_q;
                end
            end
            S_DONE: begin
                gnt_d = 4'b0000;
            end
            default: begin
                gnt_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'd0;
            last_q    <= 2'd3;
            done_id_q <= 2'd0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            done_id_q <= done_id_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_xor_share_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_xor_share_arbiter
// Brief    : Directed and randomized checks of xor_share_arbiter against a model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_xor_share_arbiter;
    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH + 1;  // busy-rise edge to done-rise edge
    localparam int SPACE = WIDTH + 3;

    logic clk;
    logic rst_n;
    int   cyc;
    int   done_cnt;
    int   checks;
    int   errors;
    int   rr_ptr;
    logic [7:0] a_op [4];
    logic [7:0] b_op [4];

    xor_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    xor_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    initial done_cnt = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    // Round-robin rule: first requester set, looking upward after ptr.
    function automatic int rr_pick(logic [3:0] r, int ptr);
        for (int k = 1; k <= 4; k++)
            if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic drive_operands();
        for (int i = 0; i < 4; i++) begin
            bus.a_in[i*8 +: 8] = a_op[i];
            bus.b_in[i*8 +: 8] = b_op[i];
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rr_ptr = 3;
    endtask

    // Waits for the next operation start and its done pulse; no checks here.
    task automatic observe(output logic [3:0] g, output logic [1:0] id,
                           output logic [7:0] res, output int t_start,
                           output int t_done, output bit gnt_bad, output bit timeout);
        logic prev;
        prev = bus.busy;
        g = 4'h0; id = 2'd0; res = 8'h00; t_start = -1; t_done = 0;
        gnt_bad = 1'b0; timeout = 1'b1;
        for (int i = 0; i < 40 && t_start < 0; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1 && prev !== 1'b1) begin
                t_start = cyc;
                g       = bus.gnt;
            end
            prev = bus.busy;
        end
        if (t_start < 0) return;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.gnt !== g || $countones(g) != 1) gnt_bad = 1'b1;
            if (bus.done === 1'b1) begin
                t_done  = cyc;
                id      = bus.done_id;
                res     = bus.result;
                timeout = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        bus.req = 4'h0; bus.a_in = '0; bus.b_in = '0;
        rst_n = 1'b0;
        #7;
        checks++;
        if (bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.done_id !== 2'd0 || bus.result !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b id=%0d res=%h, want all 0",
                     bus.gnt, bus.busy, bus.done, bus.done_id, bus.result);
        end
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        rr_ptr = 3;
    endtask

    task automatic test_single();
        logic [3:0] g; logic [1:0] id; logic [7:0] res;
        int ts, td, d0; bit gb, to;
        @(negedge clk);
        a_op[0] = 8'hA5; b_op[0] = 8'h0F; drive_operands();
        d0 = done_cnt;
        bus.req = 4'b0001;
        observe(g, id, res, ts, td, gb, to);
        bus.req = 4'h0;
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: no done seen"); end
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
        checks++;
        if (res !== 8'hAA || id !== 2'd0) begin
            errors++; $display("FAIL single_result: got %h/%0d want aa/0", res, id);
        end
        checks++;
        if (td - ts !== LAT) begin
            errors++; $display("FAIL single_latency: got %0d want %0d", td - ts, LAT);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_done_pulse: got %0d pulses busy=%b want 1/0",
                               done_cnt - d0, bus.busy);
        end
        rr_ptr = 0;
    endtask

    task automatic test_all_pending();
        logic [3:0] g; logic [1:0] id; logic [7:0] res;
        int ts, td, prev_ts, w; bit gb, to;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            a_op[i] = 8'h11 * (i + 1) + 8'h03; b_op[i] = 8'h5C ^ 8'(i * 37);
        end
        drive_operands();
        bus.req = 4'b1111;
        prev_ts = 0;
        for (int n = 0; n < 5; n++) begin
            observe(g, id, res, ts, td, gb, to);
            w = rr_pick(4'b1111, rr_ptr);
            checks++;
            if (to || gb || g !== (4'b0001 << w) || id !== 2'(w) ||
                res !== (a_op[w] ^ b_op[w])) begin
                errors++;
                $display("FAIL all_pending_op%0d: got gnt=%b id=%0d res=%h to=%0b gb=%0b want gnt=%b res=%h",
                         n, g, id, res, to, gb, 4'b0001 << w, a_op[w] ^ b_op[w]);
            end
            if (n > 0) begin
                checks++;
                if (ts - prev_ts !== SPACE) begin
                    errors++; $display("FAIL all_pending_spacing: got %0d want %0d", ts - prev_ts, SPACE);
                end
            end
            prev_ts = ts;
            rr_ptr  = w;
        end
        bus.req = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0] g, prev_g; logic [1:0] id; logic [7:0] res;
        int ts, td, w; bit gb, to;
        @(negedge clk);
        bus.req = 4'b1010;
        prev_g  = 4'h0;
        for (int n = 0; n < 4; n++) begin
            observe(g, id, res, ts, td, gb, to);
            w = rr_pick(4'b1010, rr_ptr);
            checks++;
            if (to || g !== (4'b0001 << w) || g === prev_g || res !== (a_op[w] ^ b_op[w])) begin
                errors++;
                $display("FAIL fairness_op%0d: got gnt=%b res=%h prev=%b want gnt=%b res=%h",
                         n, g, res, prev_g, 4'b0001 << w, a_op[w] ^ b_op[w]);
            end
            prev_g = g;
            rr_ptr = w;
        end
        bus.req = 4'h0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_operand_hold();
        logic [3:0] g; logic [1:0] id; logic [7:0] res;
        int ts, td; bit gb, to;
        @(negedge clk);
        a_op[1] = 8'hFF; b_op[1] = 8'hFF; drive_operands();
        bus.req = 4'b0010;
        fork
            observe(g, id, res, ts, td, gb, to);
            begin
                repeat (4) @(posedge clk);
                #2 bus.a_in[15:8] = 8'h00;
            end
        join
        bus.req = 4'h0;
        checks++;
        if (to || g !== 4'b0010 || res !== 8'h00 || id !== 2'd1) begin
            errors++;
            $display("FAIL operand_hold: got gnt=%b res=%h id=%0d to=%0b want 0010/00/1", g, res, id, to);
        end
        rr_ptr  = 1;
        a_op[1] = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_boundary();
        logic [3:0] g; logic [1:0] id; logic [7:0] res;
        int ts, td; bit gb, to;
        logic [1:0] who [2];
        logic [7:0] av  [2];
        logic [7:0] bv  [2];
        logic [7:0] ex  [2];
        who[0] = 2'd0; av[0] = 8'h00; bv[0] = 8'hFF; ex[0] = 8'hFF;
        who[1] = 2'd3; av[1] = 8'h80; bv[1] = 8'h01; ex[1] = 8'h81;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            a_op[who[n]] = av[n]; b_op[who[n]] = bv[n]; drive_operands();
            bus.req = 4'b0001 << who[n];
            observe(g, id, res, ts, td, gb, to);
            bus.req = 4'h0;
            checks++;
            if (to || res !== ex[n] || id !== who[n]) begin
                errors++;
                $display("FAIL boundary_%0d: got res=%h id=%0d to=%0b want %h/%0d", n, res, id, to, ex[n], who[n]);
            end
            rr_ptr = who[n];
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] g; logic [1:0] id; logic [7:0] res;
        int ts, td, d0; bit gb, to;
        @(negedge clk);
        a_op[2] = 8'h3C; b_op[2] = 8'h96; drive_operands();
        bus.req = 4'b0100;
        d0 = done_cnt;
        // Edge 1 -> LOAD, edge 2 -> SHIFT with count 0, four SHIFT edges -> count 4.
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 4'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.done_id !== 2'd0 || bus.result !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got gnt=%b busy=%b done=%b id=%0d res=%h want all 0",
                     bus.gnt, bus.busy, bus.done, bus.done_id, bus.result);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        rst_n  = 1'b1;
        rr_ptr = 3;
        observe(g, id, res, ts, td, gb, to);
        bus.req = 4'h0;
        checks++;
        if (to || g !== 4'b0100 || res !== 8'hAA || id !== 2'd2 || td - ts !== LAT) begin
            errors++;
            $display("FAIL reset_mid_restart: got gnt=%b res=%h id=%0d lat=%0d to=%0b want 0100/aa/2/%0d",
                     g, res, id, td - ts, to, LAT);
        end
        rr_ptr = 2;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0] g, r; logic [1:0] id; logic [7:0] res;
        int ts, td, w, d0; bit gb, to;
        logic [7:0] exp_res;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                a_op[i] = 8'($urandom); b_op[i] = 8'($urandom);
            end
            drive_operands();
            r = 4'($urandom_range(1, 15));
            w = rr_pick(r, rr_ptr);
            exp_res = a_op[w] ^ b_op[w];
            d0 = done_cnt;
            bus.req = r;
            fork
                observe(g, id, res, ts, td, gb, to);
                begin
                    repeat ($urandom_range(2, 8)) @(posedge clk);
                    #2;
                    bus.a_in = {$urandom, $urandom};
                    if ($urandom_range(0, 1) == 1) bus.req = 4'h0;
                end
            join
            bus.req = 4'h0;
            checks++;
            if (to || gb || g !== (4'b0001 << w) || id !== 2'(w) || res !== exp_res || td - ts !== LAT) begin
                errors++;
                $display("FAIL random_%0d: req=%b got gnt=%b id=%0d res=%h lat=%0d want gnt=%b res=%h lat=%0d",
                         n, r, g, id, res, td - ts, 4'b0001 << w, exp_res, LAT);
            end
            rr_ptr = w;
            repeat (2) @(negedge clk);
            checks++;
            if (done_cnt - d0 !== 1 || bus.busy !== 1'b0 || bus.result !== exp_res) begin
                errors++;
                $display("FAIL random_after_%0d: got pulses=%0d busy=%b res=%h want 1/0/%h",
                         n, done_cnt - d0, bus.busy, bus.result, exp_res);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rr_ptr = 3;
        for (int i = 0; i < 4; i++) begin a_op[i] = 8'h00; b_op[i] = 8'h00; end
        test_reset();
        test_single();
        test_all_pending();
        test_fairness();
        test_operand_hold();
        test_boundary();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/xor_share_arbiter.md
XOR_SHARE_ARBITER -- requirements
Module: xor_share_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 2..16.
REQ-002 The block SHALL have a fixed requester count of 4, indexed 0..3.
REQ-003 Port clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port req  input  4  level request, one bit per requester.
REQ-006 Port a_in  input  4*WIDTH  operand A; requester i SHALL occupy bits [i*WIDTH +: WIDTH].
REQ-007 Port b_in  input  4*WIDTH  operand B; same packing as a_in.
REQ-008 Port gnt  output  4  one-hot grant, registered.
REQ-009 Port busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port done  output  1  single-cycle completion pulse.
REQ-011 Port done_id  output  2  index of the requester whose result is on result.
REQ-012 Port result  output  WIDTH  A XOR B of the last completed operation.

Function
REQ-013 The block SHALL contain exactly one 1-bit XOR cell built from four 2-input NAND gates; every result bit SHALL be produced through that cell.
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SHIFT, DONE.
REQ-015 IDLE: if any req bit is high at an edge, the FSM SHALL move to LOAD and set gnt to the winner; otherwise it SHALL stay in IDLE with gnt=0.
REQ-016 The winner SHALL be chosen round-robin: first set req bit, searching upward with wrap from the index after the last-served pointer.
REQ-017 LOAD: on the next edge, the granted requester's a_in/b_in slices SHALL be captured into two shift registers, the bit counter SHALL clear to 0, and the FSM SHALL move to SHIFT.
REQ-018 SHIFT: each edge SHALL XOR the shift-register LSBs through the shared cell, shift the result in at the MSB of the accumulator, shift both operands right, and increment the counter.
REQ-019 After exactly WIDTH SHIFT edges, the FSM SHALL move to DONE, with the accumulator holding the full result in bit order.
REQ-020 On entry to DONE, result and done_id SHALL be updated and the last-served pointer SHALL be set to the granted index.
REQ-021 done SHALL be high for exactly the one DONE cycle.
REQ-022 The next edge after DONE SHALL return the FSM to IDLE and clear gnt.
REQ-023 gnt SHALL remain stable and one-hot from LOAD through DONE inclusive.
REQ-024 Latency: with request-sampling edge E0, done SHALL be high in the cycle after edge E0+WIDTH+1 (WIDTH+2 edges); the minimum spacing between operations SHALL be WIDTH+3 cycles.
REQ-025 Operand changes after the LOAD capture edge SHALL NOT affect the result.
REQ-026 If req drops during LOAD, SHIFT or DONE, the operation SHALL complete unchanged, and done SHALL still fire.
REQ-027 If the granted requester still holds req in DONE, it SHALL NOT be regranted while another requester is pending.
REQ-028 Requests arriving while busy SHALL be held off, not lost, as long as req is held; no queuing SHALL exist beyond the level req.
REQ-029 result and done_id SHALL hold their values until the next DONE.

Reset
REQ-030 While rst_n is low, the block SHALL immediately force state=IDLE, gnt=0, busy=0, done=0, done_id=0, result=0, counter=0, and last-served pointer=3, so requester 0 wins first.
REQ-031 A reset asserted mid-operation SHALL abort it with no done pulse.
REQ-032 After rst_n rises, the first edge SHALL be treated as a normal IDLE edge.

Verification
REQ-033 The bench SHALL cover these directed scenarios, all at WIDTH=8:
- Single request: req=0001, a0=8'hA5, b0=8'h0F -> gnt=0001, done pulse 10 edges after sampling, result=8'hAA, done_id=0.
- All pending after reset: req=1111 held, operands distinct -> grant order 0,1,2,3,0; each result correct; operation starts exactly 11 cycles apart.
- Fairness: req=1010 held -> grants alternate 1,3,1,3; requester 1 is never served twice in a row.
- Operand hold: a1=8'hFF, b1=8'hFF, then a1 changes to 8'h00 during SHIFT -> result=8'h00 (LOAD-time values used).
- Reset mid-SHIFT: rst_n low at counter=4 -> all outputs 0 asynchronously, no done; after release with req=0100 held -> fresh operation, correct result.
- Boundary data: a=8'h00, b=8'hFF -> 8'hFF; a=8'h80, b=8'h01 -> 8'h81 (MSB/LSB ordering check).
